po2_weight_encoder: RTL and testbench

//   Encodes a signed fixed-point weight into the power-of-two form consumed by
//   po2_multiply: zero flag, sign flag and right-shift amount log_2_weight (|w| ~= 2^-k).

---
 rtl/po2_weight_encoder_if.sv | 24 ++
 rtl/po2_weight_encoder.sv | 126 ++++++++++++
 tb/tb_po2_weight_encoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/po2_weight_encoder_if.sv
// Weight-in / shift-code-out handshake bundle between a weight source and po2_weight_encoder.
interface po2_weight_encoder_if #(
  parameter int W = 16
);
  logic [W-1:0] weight;
  logic         in_v;
  logic         in_ready;
  logic         zero_weight;
  logic         negative_weight;
  logic [W-1:0] log_2_weight;
  logic         saturated;
  logic         out_v;
  logic         out_ready;

  modport master (
    output weight, in_v, out_ready,
    input  in_ready, zero_weight, negative_weight, log_2_weight, saturated, out_v
  );

  modport slave (
    input  weight, in_v, out_ready,
    output in_ready, zero_weight, negative_weight, log_2_weight, saturated, out_v
  );
endinterface

// File: rtl/po2_weight_encoder.sv
// Encodes a signed Q(I).(F) weight into zero/sign/right-shift form (|w| ~= 2^-k) for po2_multiply.
// IDLE capture | ABS sign+magnitude | SCAN normalise, count zeros | ROUND emit k | HOLD await out_ready
module po2_weight_encoder #(
  parameter int W = 16,
  parameter int I = 4
) (
  input  logic                clk,
  input  logic                rst,
  po2_weight_encoder_if.slave bus
);
  localparam int CW = $clog2(W);
  localparam int KW = $clog2(W) + 2;

  typedef enum logic [2:0] {IDLE, ABS, SCAN, ROUND, HOLD} state_t;

  state_t        state, state_nxt;
  logic [W-1:0]  w_q, w_nxt;
  logic [W-1:0]  mag, mag_nxt;
  logic [W-1:0]  k_q, k_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          neg, neg_nxt;
  logic          zero_q, zero_nxt;
  logic          neg_out, neg_out_nxt;
  logic          sat_q, sat_nxt;
  logic          ov_q, ov_nxt;
  logic [KW-1:0] k_raw;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      w_q     <= '0;
      mag     <= '0;
      k_q     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
      zero_q  <= 1'b0;
      neg_out <= 1'b0;
      sat_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      w_q     <= w_nxt;
      mag     <= mag_nxt;
      k_q     <= k_nxt;
      cnt     <= cnt_nxt;
      neg     <= neg_nxt;
      zero_q  <= zero_nxt;
      neg_out <= neg_out_nxt;
      sat_q   <= sat_nxt;
      ov_q    <= ov_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    w_nxt       = w_q;
    mag_nxt     = mag;
    k_nxt       = k_q;
    cnt_nxt     = cnt;
    neg_nxt     = neg;
    zero_nxt    = zero_q;
    neg_out_nxt = neg_out;
    sat_nxt     = sat_q;
    ov_nxt      = ov_q;
    // Bit below the leading one decides rounding: mantissa >= 1.5 rounds to the next power.
    k_raw       = KW'(cnt) - KW'(I - 1) - KW'(mag[W-2]);
    case (state)
      IDLE: begin
        if (bus.in_v) begin
          w_nxt     = bus.weight;
          state_nxt = ABS;
        end
      end
      ABS: begin
        neg_nxt = w_q[W-1];
        mag_nxt = w_q[W-1] ? (~w_q + W'(1)) : w_q;
        if (w_q == '0) begin
          zero_nxt    = 1'b1;
          neg_out_nxt = 1'b0;
          k_nxt       = '0;
          sat_nxt     = 1'b0;
          ov_nxt      = 1'b1;
          state_nxt   = HOLD;
        end else begin
          cnt_nxt   = '0;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (mag[W-1]) begin
          state_nxt = ROUND;
        end else begin
          mag_nxt = mag << 1;
          cnt_nxt = cnt + CW'(1);
        end
      end
      ROUND: begin
        if (k_raw[KW-1]) begin
          k_nxt   = '0;
          sat_nxt = 1'b1;
        end else begin
          k_nxt   = W'(k_raw);
          sat_nxt = 1'b0;
        end
        neg_out_nxt = neg;
        zero_nxt    = 1'b0;
        ov_nxt      = 1'b1;
        state_nxt   = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          ov_nxt    = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready        = (state == IDLE);
  assign bus.out_v           = ov_q;
  assign bus.zero_weight     = zero_q;
  assign bus.negative_weight = neg_out;
  assign bus.log_2_weight    = k_q;
  assign bus.saturated       = sat_q;
endmodule

// File: tb/tb_po2_weight_encoder.sv
// Directed-vector bench for po2_weight_encoder (W=16, I=4) with hand-computed expectations.
module tb_po2_weight_encoder;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] obs_k;
  logic        obs_neg;
  logic        obs_zero;

  po2_weight_encoder_if #(.W(16)) bus_i ();

  po2_weight_encoder #(.W(16), .I(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_i)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst = 1'b1;
    bus_i.in_v = 1'b0;
    bus_i.weight = '0;
    bus_i.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus_i.out_v !== 1'b0) begin n_bad++; $display("FAIL reset_out_v got %b want 0", bus_i.out_v); end
    n_cmp++; if (bus_i.zero_weight !== 1'b0) begin n_bad++; $display("FAIL reset_zero got %b want 0", bus_i.zero_weight); end
    n_cmp++; if (bus_i.negative_weight !== 1'b0) begin n_bad++; $display("FAIL reset_neg got %b want 0", bus_i.negative_weight); end
    n_cmp++; if (bus_i.saturated !== 1'b0) begin n_bad++; $display("FAIL reset_sat got %b want 0", bus_i.saturated); end
    n_cmp++; if (bus_i.log_2_weight !== 16'h0000) begin n_bad++; $display("FAIL reset_k got %h want 0000", bus_i.log_2_weight); end
    rst = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++; if (bus_i.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", bus_i.in_ready); end
  endtask

  // Sends one weight, measures latency from the accepting edge and checks the result; leaves HOLD pending.
  task automatic send_check(input logic [15:0] w, input logic [15:0] ek, input logic en,
                            input logic es, input logic ez, input int el, input string nm);
    int g;
    int lat;
    g = 0;
    while (bus_i.in_ready !== 1'b1 && g < 20) begin @(posedge clk); #1; g++; end
    n_cmp++; if (bus_i.in_ready !== 1'b1) begin n_bad++; $display("FAIL %s in_ready_wait got %b want 1", nm, bus_i.in_ready); end
    bus_i.weight = w;
    bus_i.in_v = 1'b1;
    @(posedge clk);
    #1;
    bus_i.in_v = 1'b0;
    lat = 0;
    while (bus_i.out_v !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
    obs_k = bus_i.log_2_weight;
    obs_neg = bus_i.negative_weight;
    obs_zero = bus_i.zero_weight;
    n_cmp++; if (bus_i.out_v !== 1'b1) begin n_bad++; $display("FAIL %s out_v_timeout got %b want 1", nm, bus_i.out_v); end
    n_cmp++; if (lat !== el) begin n_bad++; $display("FAIL %s latency got %0d want %0d", nm, lat, el); end
    n_cmp++; if (bus_i.log_2_weight !== ek) begin n_bad++; $display("FAIL %s k got %0d want %0d", nm, bus_i.log_2_weight, ek); end
    n_cmp++; if (bus_i.negative_weight !== en) begin n_bad++; $display("FAIL %s neg got %b want %b", nm, bus_i.negative_weight, en); end
    n_cmp++; if (bus_i.saturated !== es) begin n_bad++; $display("FAIL %s sat got %b want %b", nm, bus_i.saturated, es); end
    n_cmp++; if (bus_i.zero_weight !== ez) begin n_bad++; $display("FAIL %s zero got %b want %b", nm, bus_i.zero_weight, ez); end
  endtask

  task automatic release_out(input string nm);
    bus_i.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_i.out_ready = 1'b0;
    n_cmp++; if (bus_i.out_v !== 1'b0) begin n_bad++; $display("FAIL %s out_v_after_accept got %b want 0", nm, bus_i.out_v); end
    n_cmp++; if (bus_i.in_ready !== 1'b1) begin n_bad++; $display("FAIL %s in_ready_after_accept got %b want 1", nm, bus_i.in_ready); end
  endtask

  task automatic test_vectors();
    send_check(16'h1000, 16'd0,  1'b0, 1'b0, 1'b0, 6,  "one");       release_out("one");
    send_check(16'h0C00, 16'd0,  1'b0, 1'b0, 1'b0, 7,  "p75");       release_out("p75");
    send_check(16'h0B33, 16'd1,  1'b0, 1'b0, 1'b0, 7,  "p70");       release_out("p70");
    send_check(16'hFC00, 16'd2,  1'b1, 1'b0, 1'b0, 8,  "m25");       release_out("m25");
    send_check(16'h0001, 16'd12, 1'b0, 1'b0, 1'b0, 18, "lsb");       release_out("lsb");
    send_check(16'h8000, 16'd0,  1'b1, 1'b1, 1'b0, 3,  "most_neg");  release_out("most_neg");
    send_check(16'h2000, 16'd0,  1'b0, 1'b1, 1'b0, 5,  "two");       release_out("two");
    send_check(16'h0000, 16'd0,  1'b0, 1'b0, 1'b1, 1,  "zero");      release_out("zero");
  endtask

  task automatic test_back_to_back();
    int busy;
    send_check(16'hFC00, 16'd2, 1'b1, 1'b0, 1'b0, 8, "hold");
    for (int i = 0; i < 10; i++) begin
      bus_i.weight = 16'h1000;
      bus_i.in_v = (i % 2 == 0);
      @(posedge clk);
      #1;
      n_cmp++; if (bus_i.out_v !== 1'b1) begin n_bad++; $display("FAIL hold_out_v cycle %0d got %b want 1", i, bus_i.out_v); end
      n_cmp++; if (bus_i.log_2_weight !== 16'd2 || bus_i.negative_weight !== 1'b1) begin
        n_bad++; $display("FAIL hold_stable cycle %0d got k=%0d neg=%b want k=2 neg=1", i, bus_i.log_2_weight, bus_i.negative_weight);
      end
      n_cmp++; if (bus_i.in_ready !== 1'b0) begin n_bad++; $display("FAIL hold_in_ready cycle %0d got %b want 0", i, bus_i.in_ready); end
    end
    bus_i.in_v = 1'b0;
    release_out("hold");
    busy = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (bus_i.out_v !== 1'b0 || bus_i.in_ready !== 1'b1) busy++;
    end
    n_cmp++; if (busy !== 0) begin n_bad++; $display("FAIL hold_ignored_pulses busy_cycles got %0d want 0", busy); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus_i.weight = 16'h0001;
    bus_i.in_v = 1'b1;
    @(posedge clk);
    #1;
    bus_i.in_v = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++; if (bus_i.out_v !== 1'b0) begin n_bad++; $display("FAIL midrst_out_v got %b want 0", bus_i.out_v); end
    n_cmp++; if (bus_i.log_2_weight !== 16'd0) begin n_bad++; $display("FAIL midrst_k got %0d want 0", bus_i.log_2_weight); end
    n_cmp++; if (bus_i.negative_weight !== 1'b0) begin n_bad++; $display("FAIL midrst_neg got %b want 0", bus_i.negative_weight); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (bus_i.out_v === 1'b1) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midrst_abandoned out_v_cycles got %0d want 0", seen); end
    send_check(16'hFC00, 16'd2, 1'b1, 1'b0, 1'b0, 8, "after_rst");
    release_out("after_rst");
  endtask

  // po2_multiply reference: product = inp >>> k, negated for negative weights, 0 for zero weights.
  task automatic test_chain();
    logic signed [15:0] inp;
    logic signed [15:0] sh;
    logic signed [15:0] prod;
    logic [15:0] ws [4];
    logic [15:0] eks [4];
    logic        ens [4];
    logic        ezs [4];
    int          els [4];
    logic [15:0] eps [4];
    inp = 16'sh3000;
    ws[0] = 16'h0B33; eks[0] = 16'd1;  ens[0] = 1'b0; ezs[0] = 1'b0; els[0] = 7;  eps[0] = 16'h1800;
    ws[1] = 16'hFC00; eks[1] = 16'd2;  ens[1] = 1'b1; ezs[1] = 1'b0; els[1] = 8;  eps[1] = 16'hF400;
    ws[2] = 16'h0001; eks[2] = 16'd12; ens[2] = 1'b0; ezs[2] = 1'b0; els[2] = 18; eps[2] = 16'h0003;
    ws[3] = 16'h0000; eks[3] = 16'd0;  ens[3] = 1'b0; ezs[3] = 1'b1; els[3] = 1;  eps[3] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      send_check(ws[i], eks[i], ens[i], 1'b0, ezs[i], els[i], "chain");
      sh = inp >>> obs_k;
      prod = obs_zero ? 16'sh0000 : (obs_neg ? -sh : sh);
      n_cmp++; if (prod !== eps[i]) begin n_bad++; $display("FAIL chain_product w=%h got %h want %h", ws[i], prod, eps[i]); end
      release_out("chain");
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_mid();
    test_chain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
